// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the parametrised CPU register file.
package reg_file_pkg;

  localparam int unsigned RF_DATA_W = 8;
  localparam int unsigned RF_DEPTH  = 8;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_SWEEP
  } sweep_state_e;

endpackage

// File: rtl/reg_file_sweep_ctrl.sv
// Background CLEAR sweep sequencer: walks the array one entry per cycle, zeroing it.
module reg_file_sweep_ctrl
  import reg_file_pkg::*;
#(
  parameter int unsigned DEPTH  = RF_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLEAR,
  output logic              BUSY,
  output logic              sweep_en,
  output logic [ADDR_W-1:0] sweep_addr
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  sweep_state_e      state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (CLEAR) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      ST_SWEEP: begin
        // CLEAR is deliberately ignored here; the sweep always runs to completion.
        if (cnt_q == LastAddr) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign BUSY       = (state_q == ST_SWEEP);
  assign sweep_en   = BUSY;
  assign sweep_addr = cnt_q;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two registered write-first read ports,
// optional hard-wired zero register and a background zeroing sweep.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned ZERO_REG = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  input  logic              CLEAR,
  output logic              BUSY
);

  localparam logic [ADDR_W:0] DepthExt = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] out1_q, out1_d;
  logic [DATA_W-1:0] out2_q, out2_d;
  logic              sweep_en;
  logic [ADDR_W-1:0] sweep_addr;
  logic              wr_ok;

  reg_file_sweep_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sweep_ctrl (
    .CLK        (CLK),
    .RESET      (RESET),
    .CLEAR      (CLEAR),
    .BUSY       (BUSY),
    .sweep_en   (sweep_en),
    .sweep_addr (sweep_addr)
  );

  // Entry is addressable and not the hard-wired zero register.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DepthExt) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok = WRITE && !BUSY && addr_live(INADDRESS);

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[INADDRESS] = IN;
    if (sweep_en) mem_d[sweep_addr] = '0;
    // Reads see the post-edge contents, giving write-first forwarding.
    out1_d = '0;
    out2_d = '0;
    if (addr_live(OUT1ADDRESS)) out1_d = mem_d[OUT1ADDRESS];
    if (addr_live(OUT2ADDRESS)) out2_d = mem_d[OUT2ADDRESS];
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      out1_q <= '0;
      out2_q <= '0;
    end else begin
      mem_q  <= mem_d;
      out1_q <= out1_d;
      out2_q <= out2_d;
    end
  end

  assign OUT1 = out1_q;
  assign OUT2 = out2_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench: three configurations (default, ZERO_REG=1, DEPTH=6) share one
// stimulus stream; a reference model pushes expected outputs, compared after each edge.
module tb_reg_file_param;

  typedef struct {
    logic [7:0] o1;
    logic [7:0] o2;
    logic       busy;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [7:0] IN = '0;
  logic [2:0] INADDRESS = '0;
  logic       WRITE = 1'b0;
  logic [2:0] OUT1ADDRESS = '0;
  logic [2:0] OUT2ADDRESS = '0;
  logic       CLEAR = 1'b0;

  logic [7:0] out1 [3];
  logic [7:0] out2 [3];
  logic       busy [3];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state
  logic [7:0] m_mem  [3][8];
  logic       m_busy [3];
  int         m_cnt  [3];
  int         cfg_depth [3] = '{8, 8, 6};
  bit         cfg_zr    [3] = '{1'b0, 1'b1, 1'b0};
  exp_t       sb_q [$];

  always #5 CLK = ~CLK;

  reg_file_param #(.DATA_W(8), .DEPTH(8), .ADDR_W(3), .ZERO_REG(0)) u_dut_def (
    .CLK (CLK), .RESET (RESET), .IN (IN), .INADDRESS (INADDRESS), .WRITE (WRITE),
    .OUT1ADDRESS (OUT1ADDRESS), .OUT2ADDRESS (OUT2ADDRESS), .OUT1 (out1[0]),
    .OUT2 (out2[0]), .CLEAR (CLEAR), .BUSY (busy[0])
  );

  reg_file_param #(.DATA_W(8), .DEPTH(8), .ADDR_W(3), .ZERO_REG(1)) u_dut_zr (
    .CLK (CLK), .RESET (RESET), .IN (IN), .INADDRESS (INADDRESS), .WRITE (WRITE),
    .OUT1ADDRESS (OUT1ADDRESS), .OUT2ADDRESS (OUT2ADDRESS), .OUT1 (out1[1]),
    .OUT2 (out2[1]), .CLEAR (CLEAR), .BUSY (busy[1])
  );

  reg_file_param #(.DATA_W(8), .DEPTH(6), .ADDR_W(3), .ZERO_REG(0)) u_dut_d6 (
    .CLK (CLK), .RESET (RESET), .IN (IN), .INADDRESS (INADDRESS), .WRITE (WRITE),
    .OUT1ADDRESS (OUT1ADDRESS), .OUT2ADDRESS (OUT2ADDRESS), .OUT1 (out1[2]),
    .OUT2 (out2[2]), .CLEAR (CLEAR), .BUSY (busy[2])
  );

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %02h, required %02h", tag, obs, exp);
  endtask

  function automatic logic [7:0] model_read(int c, logic [7:0] nxt [8], logic [2:0] a);
    if (int'(a) >= cfg_depth[c]) return 8'h00;
    if (cfg_zr[c] && a == 3'd0) return 8'h00;
    return nxt[a];
  endfunction

  // Drive one cycle of stimulus, predict every configuration, then compare after the edge.
  task automatic step(input logic rst, input logic clr, input logic we, input logic [2:0] ia,
                      input logic [7:0] din, input logic [2:0] a1, input logic [2:0] a2);
    logic [7:0] nxt [8];
    exp_t       e;
    RESET = rst; CLEAR = clr; WRITE = we; INADDRESS = ia; IN = din;
    OUT1ADDRESS = a1; OUT2ADDRESS = a2;
    for (int c = 0; c < 3; c++) begin
      if (!rst) begin
        for (int i = 0; i < 8; i++) m_mem[c][i] = 8'h00;
        m_busy[c] = 1'b0;
        m_cnt[c]  = 0;
        e = '{o1: 8'h00, o2: 8'h00, busy: 1'b0};
      end else begin
        nxt = m_mem[c];
        if (we && !m_busy[c] && int'(ia) < cfg_depth[c] && !(cfg_zr[c] && ia == 3'd0))
          nxt[ia] = din;
        if (m_busy[c]) nxt[m_cnt[c]] = 8'h00;
        e.o1 = model_read(c, nxt, a1);
        e.o2 = model_read(c, nxt, a2);
        if (!m_busy[c]) begin
          if (clr) begin
            m_busy[c] = 1'b1;
            m_cnt[c]  = 0;
          end
        end else if (m_cnt[c] == cfg_depth[c] - 1) begin
          m_busy[c] = 1'b0;
          m_cnt[c]  = 0;
        end else begin
          m_cnt[c]++;
        end
        e.busy = m_busy[c];
        m_mem[c] = nxt;
      end
      sb_q.push_back(e);
    end
    @(posedge CLK);
    #1;
    for (int c = 0; c < 3; c++) begin
      e = sb_q.pop_front();
      check_val($sformatf("cfg%0d.out1@a%0d", c, a1), out1[c], e.o1);
      check_val($sformatf("cfg%0d.out2@a%0d", c, a2), out2[c], e.o2);
      check_val($sformatf("cfg%0d.busy", c), {7'd0, busy[c]}, {7'd0, e.busy});
    end
  endtask

  task automatic idle_read(input logic [2:0] a1, input logic [2:0] a2);
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, a1, a2);
  endtask

  initial begin
    int busy_len;

    // Reset, then read every address
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    step(1'b0, 1'b1, 1'b1, 3'd2, 8'h99, 3'd2, 3'd2);
    for (int i = 0; i < 8; i++) idle_read(3'(i), 3'(7 - i));

    // Same-edge forwarding, then the other port next cycle
    step(1'b1, 1'b0, 1'b1, 3'd3, 8'hA5, 3'd3, 3'd0);
    idle_read(3'd0, 3'd3);

    // Zero register: write to 0 must not stick on the ZERO_REG instance
    step(1'b1, 1'b0, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd0);
    idle_read(3'd0, 3'd0);
    step(1'b1, 1'b0, 1'b1, 3'd1, 8'h11, 3'd1, 3'd0);
    idle_read(3'd1, 3'd1);

    // Fill, then sweep with a dropped write during BUSY
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 3'(i), 8'h10 + 8'(i), 3'(i), 3'(7 - i));
    step(1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 3'd2, 3'd5);
    busy_len = 0;
    for (int k = 0; k < 20 && busy[0]; k++) begin
      busy_len++;
      if (k == 1) step(1'b1, 1'b0, 1'b1, 3'd2, 8'h55, 3'd2, 3'd7);
      else step(1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 3'(k), 3'd7);
    end
    check_val("busy_len", 8'(busy_len), 8'd8);
    for (int i = 0; i < 8; i++) idle_read(3'(i), 3'(i));

    // Refill, start a sweep, abort with reset on the 4th BUSY cycle, then restart
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 3'(i), 8'h20 + 8'(i), 3'(i), 3'd0);
    step(1'b1, 1'b1, 1'b1, 3'd6, 8'h66, 3'd6, 3'd7);
    for (int k = 0; k < 3; k++) idle_read(3'(k), 3'd6);
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd6, 3'd7);
    for (int i = 0; i < 8; i++) idle_read(3'(i), 3'(i));
    step(1'b1, 1'b0, 1'b1, 3'd0, 8'h42, 3'd0, 3'd1);
    step(1'b1, 1'b0, 1'b1, 3'd1, 8'h43, 3'd0, 3'd1);
    step(1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd1);
    for (int k = 0; k < 9; k++) idle_read(3'd0, 3'd1);

    // Out-of-range addresses on the DEPTH=6 instance
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 3'(i), 8'h30 + 8'(i), 3'(i), 3'd0);
    step(1'b1, 1'b0, 1'b1, 3'd6, 8'h77, 3'd6, 3'd7);
    idle_read(3'd6, 3'd7);
    for (int i = 0; i < 6; i++) idle_read(3'(i), 3'(5 - i));

    // Random mix
    for (int k = 0; k < 200; k++)
      step(1'($urandom_range(0, 40) != 0), 1'($urandom_range(0, 15) == 0), 1'($urandom),
           3'($urandom), 8'($urandom), 3'($urandom), 3'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised successor to the 8x8 processor register file: DEPTH entries of DATA_W bits, one write port, two read ports. Reads are registered (one-cycle latency) with write-first forwarding. Adds an optional hard-wired zero register and a background CLEAR sweep that zeroes the array one entry per cycle without asserting reset. Sits between instruction decode (addresses) and the ALU/writeback path of the CPU datapath.

## Interface
Parameters:
- DATA_W, 8, register width in bits
- DEPTH, 8, number of registers (≥2, need not be a power of 2)
- ADDR_W, $clog2(DEPTH), address width
- ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes

Ports:
- CLK  in  1  single clock, all state updates on posedge
- RESET  in  1  synchronous, active-low reset
- IN  in  DATA_W  write data
- INADDRESS  in  ADDR_W  write address
- WRITE  in  1  write enable
- OUT1ADDRESS  in  ADDR_W  read port 1 address
- OUT2ADDRESS  in  ADDR_W  read port 2 address
- OUT1  out  DATA_W  read port 1 data, registered
- OUT2  out  DATA_W  read port 2 data, registered
- CLEAR  in  1  request to start a zeroing sweep
- BUSY  out  1  high while a sweep is in progress

## Operation
- RESET low at a posedge: all entries := 0, OUT1 = OUT2 = 0, BUSY = 0, FSM := IDLE, sweep counter := 0. RESET has priority over every other input.
- Write: at a posedge with RESET high, WRITE = 1, BUSY = 0 and INADDRESS < DEPTH: a[INADDRESS] := IN. Writes dropped when BUSY = 1, when INADDRESS ≥ DEPTH, or when ZERO_REG = 1 and INADDRESS = 0.
- Read rule (write-first): at each posedge, OUTn := next-state value of a[OUTnADDRESS], i.e. the value the entry holds after this edge's write/sweep. Same-edge write to the read address forwards IN. Both ports may read the same address.
- Address ≥ DEPTH reads 0. With ZERO_REG = 1, address 0 reads 0.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP: CLEAR = 1 at a posedge. Counter := 0. No entry is zeroed on this edge.
  - SWEEP: each posedge zeroes a[counter], then counter += 1. After the edge that zeroes entry DEPTH-1, the FSM returns to IDLE and the counter returns to 0.
  - CLEAR is ignored while in SWEEP.
- BUSY = 1 exactly while the FSM is in SWEEP.
- A read of the entry being zeroed on an edge returns 0; per the write-first rule, this is the next-state value.

## Timing
- Read latency is 1 cycle: address presented before edge k, data valid after edge k.
- Write-to-read latency is 0 extra cycles, via forwarding.
- Sweep: BUSY rises after the edge that samples CLEAR and stays high for exactly DEPTH cycles.
- Total time from CLEAR sample to BUSY low is DEPTH+1 edges.
- RESET low mid-sweep aborts the sweep: IDLE, all zero, BUSY = 0 after that edge.
- CLEAR and WRITE on the same IDLE edge: the write lands, then the sweep starts and later zeroes it.
- No combinational path from any input to OUT1, OUT2 or BUSY.

## Structure
- Shared package reg_file_pkg holds:
  - the state enum (ST_IDLE, ST_SWEEP)
  - the default width/depth localparams used by the CPU top
- Sub-module reg_file_sweep_ctrl holds the FSM and counter. It has outputs BUSY, sweep_en and sweep_addr.
- The parent holds the array, the write qualification and the registered read muxes.

## Test plan
- Reset, then read addresses 0..7 -> OUT1 = OUT2 = 0; BUSY = 0.
- Write 0xA5 to reg 3 with OUT1ADDRESS = 3 on the same edge -> OUT1 = 0xA5 after that edge. Next cycle, OUT2ADDRESS = 3 -> OUT2 = 0xA5.
- ZERO_REG = 1: write 0xFF to reg 0, then read reg 0 -> 0. Write 0x11 to reg 1 -> reads 0x11.
- Fill regs 0..7 with 0x10..0x17, pulse CLEAR -> BUSY high for exactly 8 cycles. A write of 0x55 to reg 2 during BUSY is dropped. Afterwards all regs read 0.
- Start a sweep, drive RESET low on the 4th BUSY cycle -> BUSY = 0 next cycle, all regs 0, and a new CLEAR restarts the sweep at entry 0.
- DEPTH = 6, ADDR_W = 3: write 0x77 to address 6, then read addresses 6 and 7 -> both 0; entries 0..5 unchanged.
